ex_hazard_unit: RTL and testbench
=================================

# ex_hazard_unit

Pipeline hazard controller that reads the ID/EX pipeline register outputs and drives the stage registers. It keeps its own shadow copy of the EX/MEM and MEM/WB destination fields. From these it produces three results: forwarding selects for the EX-stage ALU operands, stall/bubble controls for load-use (or, without forwarding, all RAW) hazards, and flush controls for taken branches. It sits beside the IF/ID and ID/EX registers, driving their hold/clear inputs.

## Interface
Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs_1, id_rs_2  in  5  source registers of the instruction currently in ID
- id_uses_rs_1, id_uses_rs_2  in  1  ID instruction actually reads rs_1 / rs_2
- ex_reg_rs_1, ex_reg_rs_2  in  5  source registers latched in ID/EX
- ex_reg_rd  in  5  destination latched in ID/EX
- ex_reg_write, ex_mem_read  in  1  ID/EX control fields
- branch_taken  in  1  EX-stage branch resolved taken
- stall_if_id  out  1  hold PC and IF/ID this cycle
- bubble_id_ex  out  1  load zeros into ID/EX controls at next edge
- flush_if_id  out  1  clear IF/ID at next edge
- forward_a, forward_b  out  2  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB
- hazard_state  out  2  registered last action: 0 RUN, 1 STALL, 2 FLUSH
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- Shadow pipeline, updated every edge:
  - exmem_rd <= ex_reg_rd; exmem_wr <= ex_reg_write.
  - memwb_rd <= exmem_rd; memwb_wr <= exmem_wr.
  - Always advances, because the MEM/WB stages never stall.
- Match rule: a source matches a stage only if that stage's write flag is 1, its rd != 0, and (for ID sources) the matching uses flag is 1. Register x0 never causes a hazard or a forward.
- Forwarding (combinational, for each EX source): EX/MEM match -> 10; else MEM/WB match -> 01; else 00. EX/MEM has priority when both match.
- Load-use: ex_mem_read & ex_reg_write & ex_reg_rd != 0 & an ID source matches ex_reg_rd -> stall_if_id=1, bubble_id_ex=1.
- Branch: branch_taken -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0. Branch overrides any stall in the same cycle.
- FSM (next-state = action taken this cycle):
  - RUN when no action.
  - STALL when stalling.
  - FLUSH when flushing.
  - hazard_state shows the previous cycle's action.
- stall_count increments on every cycle with stall_if_id=1 and holds at all-ones.

## Timing
- Forward/stall/flush outputs are combinational from the inputs and the shadow registers, with zero latency. hazard_state and stall_count lag one cycle.
- A load-use hazard costs exactly one stall cycle with forwarding. The dependent instruction then reaches EX with forward = 01 from the load's MEM/WB entry.
- Reset (synchronous): shadow rd/wr = 0, hazard_state = RUN, stall_count = 0. Outputs then follow their combinational rules, so forward = 00 and stall/flush/bubble = 0 unless the ID/EX inputs match.
- Reset asserted mid-stall: the next cycle behaves as if the pipeline were empty, and the stall_count increment of the reset cycle is dropped.
- Back-to-back loads with chained dependencies each cost one stall.

## Configuration
- FORWARDING_EN defined:
  - forward_a/b are generated as above.
  - Only load-use hazards stall.
- FORWARDING_EN undefined:
  - forward_a/b are tied to 00.
  - stall_if_id = bubble_id_ex = 1 whenever an ID source matches the ID/EX, EX/MEM or MEM/WB destination.
  - A dependent instruction immediately behind a producer therefore stalls 3 cycles; the register file is not write-through.
  - Branch flush is unchanged.

## Structure
- Shared package hazard_pkg:
  - fwd_sel_e (FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10).
  - hazard_state_e (HZ_RUN, HZ_STALL, HZ_FLUSH).
  - REG_ADDR_W=5.
- One sub-module, forward_select: it maps one source address plus the two shadow stage (rd, wr) pairs to a fwd_sel_e. It is instantiated twice.

## Test plan
- `lw x5` in EX (ex_mem_read=1, rd=5), ID `add` using rs_1=5 -> stall_if_id=1, bubble_id_ex=1 for 1 cycle. The next cycle has no stall; the cycle after, forward_a=01; stall_count=1.
- `add x3` in EX/MEM and `sub x3` in MEM/WB, with an EX instruction reading rs_2=3 -> forward_b=10 (priority over MEM/WB).
- Producer writes x0, consumer reads x0 -> forward 00, no stall.
- Load-use hazard coincident with branch_taken=1 -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0, next hazard_state=FLUSH.
- FORWARDING_EN undefined, with `addi x7` followed immediately by a reader of x7 -> 3 consecutive stall cycles; stall_count=3, forward stays 00.
- Reset asserted during the stall cycle -> next cycle hazard_state=RUN, stall_count=0, shadow cleared.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the EX-stage hazard controller.
//   fwd_sel_e      : ALU operand source select (register file, MEM/WB, EX/MEM)
//   hazard_state_e : last action taken by the hazard controller
//   src_hit()      : true when a source register depends on a stage's destination
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hazard_state_e;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                     input logic                  uses,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  wr);
        return uses && wr && (rd != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one EX-stage source register.
// Ports:
//   src_i                    : source register address latched in ID/EX
//   exmem_rd_i, exmem_wr_i   : EX/MEM destination and write flag
//   memwb_rd_i, memwb_wr_i   : MEM/WB destination and write flag
//   sel_o                    : chosen operand source
module forward_select
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  exmem_wr_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  memwb_wr_i,
    output fwd_sel_e              sel_o
);

    // EX/MEM holds the younger result, so it wins when both stages match.
    always_comb begin
        sel_o = FWD_RF;
        if (src_hit(src_i, 1'b1, exmem_rd_i, exmem_wr_i)) begin
            sel_o = FWD_EXMEM;
        end else if (src_hit(src_i, 1'b1, memwb_rd_i, memwb_wr_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use / RAW stalls and
// taken-branch flushes. Keeps a shadow copy of the EX/MEM and MEM/WB
// destination fields, which advance every cycle.
// Build option: FORWARDING_EN
//   defined   -> operand forwarding active, only load-use hazards stall
//   undefined -> forward_a/b tied to 00, any RAW dependency on ID/EX, EX/MEM
//                or MEM/WB stalls (register file is not write-through)
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   id_rs_1/2, id_uses_rs_1/2    : ID-stage sources and their use flags
//   ex_reg_rs_1/2, ex_reg_rd     : ID/EX source and destination fields
//   ex_reg_write, ex_mem_read    : ID/EX control fields
//   branch_taken                 : EX-stage branch resolved taken
//   stall_if_id, bubble_id_ex    : hold PC/IF-ID, zero ID/EX controls
//   flush_if_id                  : clear IF/ID
//   forward_a/b                  : EX operand source select
//   hazard_state                 : previous cycle's action (RUN/STALL/FLUSH)
//   stall_count                  : saturating stalled-cycle count
//
// state    | meaning
// HZ_RUN   | no hazard action last cycle
// HZ_STALL | IF/ID held and bubble inserted last cycle
// HZ_FLUSH | IF/ID cleared for a taken branch last cycle
module ex_hazard_unit
    import hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs_1,
    input  logic [REG_ADDR_W-1:0]  id_rs_2,
    input  logic                   id_uses_rs_1,
    input  logic                   id_uses_rs_2,
    input  logic [REG_ADDR_W-1:0]  ex_reg_rs_1,
    input  logic [REG_ADDR_W-1:0]  ex_reg_rs_2,
    input  logic [REG_ADDR_W-1:0]  ex_reg_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic                   branch_taken,
    output logic                   stall_if_id,
    output logic                   bubble_id_ex,
    output logic                   flush_if_id,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic [1:0]             hazard_state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [REG_ADDR_W-1:0]  exmem_rd_q, memwb_rd_q;
    logic                   exmem_wr_q, memwb_wr_q;
    hazard_state_e          state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic id_hit_ex;
    logic raw_stall;

    assign id_hit_ex = src_hit(id_rs_1, id_uses_rs_1, ex_reg_rd, ex_reg_write)
                     | src_hit(id_rs_2, id_uses_rs_2, ex_reg_rd, ex_reg_write);

`ifdef FORWARDING_EN
    fwd_sel_e sel_a, sel_b;

    forward_select u_fwd_a (
        .src_i      (ex_reg_rs_1),
        .exmem_rd_i (exmem_rd_q),
        .exmem_wr_i (exmem_wr_q),
        .memwb_rd_i (memwb_rd_q),
        .memwb_wr_i (memwb_wr_q),
        .sel_o      (sel_a)
    );

    forward_select u_fwd_b (
        .src_i      (ex_reg_rs_2),
        .exmem_rd_i (exmem_rd_q),
        .exmem_wr_i (exmem_wr_q),
        .memwb_rd_i (memwb_rd_q),
        .memwb_wr_i (memwb_wr_q),
        .sel_o      (sel_b)
    );

    assign forward_a = sel_a;
    assign forward_b = sel_b;

    // Only a load's data arrives too late to forward into the next EX.
    assign raw_stall = ex_mem_read & id_hit_ex;
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{ex_reg_rs_1, ex_reg_rs_2, ex_mem_read};
    assign forward_a         = FWD_RF;
    assign forward_b         = FWD_RF;

    // Without forwarding, the consumer waits until the producer has left MEM/WB.
    assign raw_stall = id_hit_ex
        | src_hit(id_rs_1, id_uses_rs_1, exmem_rd_q, exmem_wr_q)
        | src_hit(id_rs_2, id_uses_rs_2, exmem_rd_q, exmem_wr_q)
        | src_hit(id_rs_1, id_uses_rs_1, memwb_rd_q, memwb_wr_q)
        | src_hit(id_rs_2, id_uses_rs_2, memwb_rd_q, memwb_wr_q);
`endif

    // A taken branch kills the stalled instruction anyway, so the flush wins.
    assign flush_if_id  = branch_taken;
    assign stall_if_id  = raw_stall & ~branch_taken;
    assign bubble_id_ex = raw_stall | branch_taken;

    always_comb begin
        state_d = HZ_RUN;
        if (branch_taken) begin
            state_d = HZ_FLUSH;
        end else if (stall_if_id) begin
            state_d = HZ_STALL;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_id && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exmem_rd_q  <= '0;
            exmem_wr_q  <= 1'b0;
            memwb_rd_q  <= '0;
            memwb_wr_q  <= 1'b0;
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
        end else begin
            exmem_rd_q  <= ex_reg_rd;
            exmem_wr_q  <= ex_reg_write;
            memwb_rd_q  <= exmem_rd_q;
            memwb_wr_q  <= exmem_wr_q;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hazard_state = state_q;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_unit.sv
module tb_ex_hazard_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs_1, id_rs_2, ex_reg_rs_1, ex_reg_rs_2, ex_reg_rd;
    logic        id_uses_rs_1, id_uses_rs_2, ex_reg_write, ex_mem_read, branch_taken;
    logic        stall_if_id, bubble_id_ex, flush_if_id;
    logic [1:0]  forward_a, forward_b, hazard_state;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        st, bb, fl;
        logic [1:0]  fa, fb, hs;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    ex_hazard_unit #(.STALL_CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs_1      (id_rs_1),
        .id_rs_2      (id_rs_2),
        .id_uses_rs_1 (id_uses_rs_1),
        .id_uses_rs_2 (id_uses_rs_2),
        .ex_reg_rs_1  (ex_reg_rs_1),
        .ex_reg_rs_2  (ex_reg_rs_2),
        .ex_reg_rd    (ex_reg_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .hazard_state (hazard_state),
        .stall_count  (stall_count)
    );

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, want);
        end
    endtask

    // One cycle of stimulus: drive inputs, queue the expected outputs, advance.
    task automatic step(input logic rst,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2,
                        input logic [4:0] e1, input logic [4:0] e2,
                        input logic [4:0] erd, input logic ewr,
                        input logic emr, input logic br,
                        input logic xst, input logic xbb, input logic xfl,
                        input logic [1:0] xfa, input logic [1:0] xfb,
                        input logic [1:0] xhs, input int xsc,
                        input string nm);
        exp_t e;
        reset = rst;
        id_rs_1 = r1; id_rs_2 = r2; id_uses_rs_1 = u1; id_uses_rs_2 = u2;
        ex_reg_rs_1 = e1; ex_reg_rs_2 = e2; ex_reg_rd = erd;
        ex_reg_write = ewr; ex_mem_read = emr; branch_taken = br;
        e.name = nm; e.st = xst; e.bb = xbb; e.fl = xfl;
        e.fa = xfa; e.fb = xfb; e.hs = xhs; e.sc = 16'(xsc);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, "stall",  {15'd0, stall_if_id},  {15'd0, e.st});
                chk(e.name, "bubble", {15'd0, bubble_id_ex}, {15'd0, e.bb});
                chk(e.name, "flush",  {15'd0, flush_if_id},  {15'd0, e.fl});
                chk(e.name, "fwd_a",  {14'd0, forward_a},    {14'd0, e.fa});
                chk(e.name, "fwd_b",  {14'd0, forward_b},    {14'd0, e.fb});
                chk(e.name, "state",  {14'd0, hazard_state}, {14'd0, e.hs});
                chk(e.name, "count",  stall_count,           e.sc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        id_rs_1 = '0; id_rs_2 = '0; id_uses_rs_1 = 0; id_uses_rs_2 = 0;
        ex_reg_rs_1 = '0; ex_reg_rs_2 = '0; ex_reg_rd = '0;
        ex_reg_write = 0; ex_mem_read = 0; branch_taken = 0;
        repeat (2) @(posedge clock);
        #1;
        //    rst r1 r2 u1 u2 e1 e2 erd ewr emr br | st bb fl fa    fb    hs sc
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 0, "reset");
`ifdef FORWARDING_EN
        // lw x5 in EX, add reading x5 in ID
        step(0, 5, 6, 1, 1, 1, 0, 5, 1, 1, 0,     1, 1, 0, 2'b00, 2'b00, 0, 0, "lu_stall");
        step(0, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 1, 1, "lu_release");
        step(0, 0, 0, 0, 0, 5, 6, 8, 1, 0, 0,     0, 0, 0, 2'b01, 2'b00, 0, 1, "lu_fwd");
        // x3 produced twice, then read: EX/MEM wins
        step(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 1, "sub_x3");
        step(0, 0, 0, 0, 0, 8, 0, 3, 1, 0, 0,     0, 0, 0, 2'b01, 2'b00, 0, 1, "fwd_a_memwb");
        step(0, 0, 0, 0, 0, 0, 3, 9, 1, 0, 0,     0, 0, 0, 2'b00, 2'b10, 0, 1, "fwd_b_prio");
        step(0, 0, 0, 0, 0, 3, 9, 0, 0, 0, 0,     0, 0, 0, 2'b01, 2'b10, 0, 1, "fwd_ab");
        // load into x0, readers of x0
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0,     0, 0, 0, 2'b00, 2'b00, 0, 1, "x0_load");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 1, "x0_exmem");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 1, "x0_memwb");
        // load-use coincident with taken branch
        step(0, 0, 4, 0, 1, 0, 0, 4, 1, 1, 1,     0, 1, 1, 2'b00, 2'b00, 0, 1, "br_override");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 2, 1, "flush_state");
        // lw x1; lw x2,(x1); add ..,x2
        step(0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0,     1, 1, 0, 2'b00, 2'b00, 0, 1, "chain1_stall");
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 1, 2, "chain1_rel");
        step(0, 2, 0, 1, 0, 1, 0, 2, 1, 1, 0,     1, 1, 0, 2'b01, 2'b00, 0, 2, "chain2_stall");
        step(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 1, 3, "chain2_rel");
        step(0, 0, 0, 0, 0, 2, 0, 5, 1, 0, 0,     0, 0, 0, 2'b01, 2'b00, 0, 3, "chain_fwd");
        // reset during a stall cycle
        step(1, 6, 0, 1, 0, 0, 0, 6, 1, 1, 0,     1, 1, 0, 2'b00, 2'b00, 0, 3, "rst_stall");
        step(0, 6, 0, 1, 0, 6, 5, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 0, "rst_clear");
`else
        // addi x7 in EX, reader of x7 in ID: three stall cycles
        step(0, 0, 7, 0, 1, 0, 0, 7, 1, 0, 0,     1, 1, 0, 2'b00, 2'b00, 0, 0, "raw_stall1");
        step(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0,     1, 1, 0, 2'b00, 2'b00, 1, 1, "raw_stall2");
        step(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0,     1, 1, 0, 2'b00, 2'b00, 1, 2, "raw_stall3");
        step(0, 9, 0, 0, 0, 0, 7, 9, 1, 0, 0,     0, 0, 0, 2'b00, 2'b00, 1, 3, "raw_release");
        step(0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 3, "uses_gate");
        step(0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 3, "fwd_tied");
        // writes to x0 never stall
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 3, "x0_ex");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 3, "x0_exmem");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 3, "x0_memwb");
        // load-use coincident with taken branch
        step(0, 0, 4, 0, 1, 0, 0, 4, 1, 1, 1,     0, 1, 1, 2'b00, 2'b00, 0, 3, "br_override");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 2, 3, "flush_state");
        // reset during a stall cycle
        step(1, 6, 0, 1, 0, 0, 0, 6, 1, 1, 0,     1, 1, 0, 2'b00, 2'b00, 0, 3, "rst_stall");
        step(0, 6, 0, 1, 0, 6, 4, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 0, "rst_clear");
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 0, 0, "idle");

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
